// File: rtl/ps2kb_responder_pkg.sv
// Shared constants and types for the PS/2 keyboard responder.
// Prefix codes, frame FSM encodings, FIFO entry layout and key bit positions.
package ps2kb_responder_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int KEY_VALID = 9;
    localparam int KEY_BREAK = 8;

    typedef struct packed {
        logic       brk;
        logic [7:0] code;
    } kb_entry_t;

endpackage

// File: rtl/ps2kb_responder_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock fall detect, frame FSM, timeout.
// Ports: clk, rst (async active-low), ps2_clk/ps2_data pins in; rx_byte, byte_vld, frame_err out.
module ps2kb_responder_frame_rx
    import ps2kb_responder_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          sync_clk_d;
    logic          sync_clk;
    logic          sync_dat;
    logic          fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          to_hit;

    assign sync_clk = clk_sync[1];
    assign sync_dat = dat_sync[1];
    assign fall     = sync_clk_d & ~sync_clk;
    assign to_hit   = (state != ST_IDLE) && !fall
                   && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign rx_byte  = shreg;

    // Synchronisers idle high so a reset never fabricates a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            sync_clk_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            sync_clk_d <= sync_clk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE || fall || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_ok    <= 1'b0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (to_hit) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!sync_dat) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {sync_dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_ok <= ^{shreg, sync_dat};
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (sync_dat && par_ok) byte_vld <= 1'b1;
                        else                    frame_err <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2kb_responder.sv
// Keyboard responder for MIO region 0xD: folds F0/E0 prefixes, queues keys in a FIFO.
// Ports: clk, rst (async active-low), ps2_clk/ps2_data, rd_ack in; ps2kb_key, ps2_overflow, ps2_err out.
module ps2kb_responder
    import ps2kb_responder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ack,
    output logic [9:0] ps2kb_key,
    output logic       ps2_overflow,
    output logic       ps2_err
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        brk_pend;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic        drop;
    logic        full;
    logic        empty;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    kb_entry_t     mem [FIFO_DEPTH];
    kb_entry_t     head;

    ps2kb_responder_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frame_err(ps2_err)
    );

    // E0 is swallowed: extended keys share the entry format of plain keys.
    assign push  = byte_vld && rx_byte != PS2_BRK && rx_byte != PS2_EXT;
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign pop   = rd_ack && !empty;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= '{brk: brk_pend, code: rx_byte};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            brk_pend     <= 1'b0;
            ps2_overflow <= 1'b0;
        end else begin
            if (byte_vld) begin
                unique case (1'b1)
                    (rx_byte == PS2_BRK): brk_pend <= 1'b1;
                    (rx_byte == PS2_EXT): brk_pend <= brk_pend;
                    default:              brk_pend <= 1'b0;
                endcase
            end
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)     ps2_overflow <= 1'b1;
            else if (pop) ps2_overflow <= 1'b0;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        ps2kb_key = '0;
        if (!empty) begin
            ps2kb_key[KEY_VALID]  = 1'b1;
            ps2kb_key[KEY_BREAK]  = head.brk;
            ps2kb_key[7:0]        = head.code;
        end
    end

endmodule

// File: tb/tb_ps2kb_responder.sv
// Self-checking bench for ps2kb_responder: queue-based key model plus literal checks.
// Drives PS/2 frames on the pins and pops entries with rd_ack.
module tb_ps2kb_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ack = 1'b0;
    logic [9:0] ps2kb_key;
    logic       ps2_overflow;
    logic       ps2_err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    bit settled = 1'b0;

    logic [8:0] mq [$];
    bit         m_brk = 1'b0;
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2kb_responder #(
        .FIFO_DEPTH (8),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rd_ack      (rd_ack),
        .ps2kb_key   (ps2kb_key),
        .ps2_overflow(ps2_overflow),
        .ps2_err     (ps2_err)
    );

    function automatic logic [9:0] m_key();
        if (mq.size() == 0) return 10'h000;
        return {1'b1, mq[0]};
    endfunction

    task automatic m_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE0) begin
            if (mq.size() == 8) m_ovf = 1'b1;
            else mq.push_back({m_brk, b});
            m_brk = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ps2_err) err_cnt++;
    end

    always @(negedge clk) begin
        if (rst && settled) begin
            total++;
            if (ps2kb_key !== m_key() || ps2_overflow !== m_ovf) begin
                bad++;
                $display("FAIL model key=%h ovf=%b want key=%h ovf=%b",
                         ps2kb_key, ps2_overflow, m_key(), m_ovf);
            end
        end
    end

    task automatic send_bit(input logic v, input bit lat);
        @(negedge clk) ps2_data = v;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (lat) begin
            repeat (4) @(posedge clk);
            #1 chk("latency", ps2kb_key, 10'h21C);
        end
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic rx(input logic [7:0] b, input bit bad_par, input bit lat);
        logic [10:0] f;
        settled = 1'b0;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i], lat && i == 10);
        repeat (2) @(negedge clk);
        if (!bad_par) m_byte(b);
        settled = 1'b1;
    endtask

    task automatic pop();
        @(negedge clk) rd_ack = 1'b1;
        @(posedge clk);
        #1;
        if (mq.size() > 0) begin
            void'(mq.pop_front());
            m_ovf = 1'b0;
        end
        @(negedge clk) rd_ack = 1'b0;
    endtask

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        chk("rst_key", ps2kb_key, 10'h000);
        chk("rst_ovf", {9'd0, ps2_overflow}, 10'd0);
        chk("rst_err", {9'd0, ps2_err}, 10'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        settled = 1'b1;

        rx(8'h1C, 1'b0, 1'b1);
        chk("make_a", ps2kb_key, 10'h21C);
        pop();
        chk("pop_empty", ps2kb_key, 10'h000);

        rx(8'hF0, 1'b0, 1'b0);
        rx(8'h1C, 1'b0, 1'b0);
        chk("break_a", ps2kb_key, 10'h31C);
        pop();
        rx(8'hE0, 1'b0, 1'b0);
        rx(8'hF0, 1'b0, 1'b0);
        rx(8'h75, 1'b0, 1'b0);
        chk("ext_break", ps2kb_key, 10'h375);
        pop();

        e0 = err_cnt;
        rx(8'h1C, 1'b1, 1'b0);
        chk("par_err", 10'(err_cnt - e0), 10'd1);
        chk("par_empty", ps2kb_key, 10'h000);

        for (int i = 1; i <= 9; i++) rx(8'(i), 1'b0, 1'b0);
        chk("ovf_set", {9'd0, ps2_overflow}, 10'd1);
        chk("ovf_head", ps2kb_key, 10'h201);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_pop", ps2kb_key, {2'b10, 8'(i)});
            pop();
            if (i == 1) chk("ovf_clr", {9'd0, ps2_overflow}, 10'd0);
        end
        chk("drained", ps2kb_key, 10'h000);

        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (150) @(negedge clk);
        chk("timeout_err", 10'(err_cnt - e0), 10'd1);
        rx(8'h2A, 1'b0, 1'b0);
        chk("after_to", ps2kb_key, 10'h22A);
        pop();

        rx(8'h11, 1'b0, 1'b0);
        rx(8'h12, 1'b0, 1'b0);
        rx(8'h13, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        settled = 1'b0;
        #1;
        chk("arst_key", ps2kb_key, 10'h000);
        chk("arst_ovf", {9'd0, ps2_overflow}, 10'd0);
        chk("arst_err", {9'd0, ps2_err}, 10'd0);
        mq.delete();
        m_brk = 1'b0;
        m_ovf = 1'b0;
        ps2_data = 1'b1;
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        settled = 1'b1;
        pop();
        chk("empty_ack", ps2kb_key, 10'h000);
        rx(8'h16, 1'b0, 1'b0);
        chk("post_rst", ps2kb_key, 10'h216);
        pop();
        settled = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
